// File: rtl/ring_buffer.sv
// ring_buffer: single-clock FIFO ring buffer with registered read data and one-cycle read acknowledge
// Ports: clk, reset (async active-low), writeEnable/data push, readEnable pop,
//        dataReadAck/dataRead registered pop result, debug/debug2 pointer and occupancy snapshots.
// Define RING_BUFFER_DEBUG_EN to build the debug words and drop counter; otherwise debug outputs are 0.
module ring_buffer #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_BITS = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  writeEnable,
  input  logic [DATA_WIDTH-1:0] data,
  input  logic                  readEnable,
  output logic                  dataReadAck,
  output logic [DATA_WIDTH-1:0] dataRead,
  output logic [31:0]           debug,
  output logic [31:0]           debug2
);
  localparam int DEPTH = 1 << ADDR_BITS;
  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [ADDR_BITS-1:0] rd_ptr, wr_ptr;
  logic [ADDR_BITS:0] count;
  logic full, empty, rd_ok, wr_ok;
  // count never exceeds depth, so its top bit alone marks full
  assign full = count[ADDR_BITS];
  assign empty = count == '0;
  assign rd_ok = readEnable & ~empty;
  // a full buffer still takes a write when a read frees a slot in the same cycle
  assign wr_ok = writeEnable & (~full | rd_ok);
  always_ff @(posedge clk)
    if (wr_ok) mem[wr_ptr] <= data;
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count <= '0;
      dataReadAck <= 1'b0;
      dataRead <= '0;
    end else begin
      dataReadAck <= rd_ok;
      if (rd_ok) dataRead <= mem[rd_ptr];
      if (rd_ok) rd_ptr <= rd_ptr + 1'b1;
      if (wr_ok) wr_ptr <= wr_ptr + 1'b1;
      count <= count + (ADDR_BITS+1)'(wr_ok) - (ADDR_BITS+1)'(rd_ok);
    end
`ifdef RING_BUFFER_DEBUG_EN
  logic [7:0] drops;
  always_ff @(posedge clk or negedge reset)
    if (!reset) drops <= '0;
    else if (writeEnable && !wr_ok && drops != 8'hff) drops <= drops + 8'd1;
  assign debug = {16'(wr_ptr), 16'(rd_ptr)};
  assign debug2 = {drops, 6'd0, empty, full, 16'(count)};
`else
  assign debug = '0;
  assign debug2 = '0;
`endif
endmodule

// File: tb/tb_ring_buffer.sv
// tb_ring_buffer: directed self-checking bench for ring_buffer
module tb_ring_buffer;
  logic clk = 0, reset = 0, writeEnable = 0, readEnable = 0;
  logic [7:0] data = 0, dataRead;
  logic dataReadAck;
  logic [31:0] debug, debug2;
  int errors = 0, checks = 0;

  ring_buffer #(.DATA_WIDTH(8), .ADDR_BITS(2)) dut (
    .clk(clk), .reset(reset), .writeEnable(writeEnable), .data(data),
    .readEnable(readEnable), .dataReadAck(dataReadAck), .dataRead(dataRead),
    .debug(debug), .debug2(debug2)
  );

  always #5 clk = ~clk;

  task automatic step(input logic we, input logic [7:0] d, input logic re);
    @(negedge clk);
    writeEnable = we; data = d; readEnable = re;
    @(posedge clk);
    #1;
    writeEnable = 0; readEnable = 0;
  endtask

  task automatic test_reset;
    reset = 0;
    repeat (3) @(posedge clk);
    @(negedge clk) reset = 1;
    #1;
    checks++; if (dataReadAck !== 1'b0) begin errors++; $display("FAIL reset_ack got %b exp 0", dataReadAck); end
    checks++; if (dataRead !== 8'h00) begin errors++; $display("FAIL reset_data got %h exp 00", dataRead); end
`ifdef RING_BUFFER_DEBUG_EN
    checks++; if (debug2 !== 32'h0002_0000) begin errors++; $display("FAIL reset_debug2 got %h exp 00020000", debug2); end
    checks++; if (debug !== 32'h0) begin errors++; $display("FAIL reset_debug got %h exp 0", debug); end
`else
    checks++; if ({debug, debug2} !== 64'h0) begin errors++; $display("FAIL reset_debug got %h %h exp 0", debug, debug2); end
`endif
    step(0, 8'h00, 1);
    checks++; if (dataReadAck !== 1'b0) begin errors++; $display("FAIL reset_empty_read got %b exp 0", dataReadAck); end
  endtask

  task automatic test_fill_order;
    step(1, 8'h01, 0);
    step(1, 8'h02, 0);
    step(1, 8'h03, 0);
    step(0, 8'h00, 1);
    checks++; if ({dataReadAck, dataRead} !== {1'b1, 8'h01}) begin errors++; $display("FAIL fill_rd1 got %b/%h exp 1/01", dataReadAck, dataRead); end
    step(0, 8'h00, 1);
    checks++; if ({dataReadAck, dataRead} !== {1'b1, 8'h02}) begin errors++; $display("FAIL fill_rd2 got %b/%h exp 1/02", dataReadAck, dataRead); end
    step(0, 8'h00, 0);
    checks++; if ({dataReadAck, dataRead} !== {1'b0, 8'h02}) begin errors++; $display("FAIL fill_ack_pulse got %b/%h exp 0/02", dataReadAck, dataRead); end
`ifdef RING_BUFFER_DEBUG_EN
    checks++; if (debug2[15:0] !== 16'd1) begin errors++; $display("FAIL fill_count got %0d exp 1", debug2[15:0]); end
`endif
  endtask

  task automatic test_overflow;
    logic [7:0] exp [4] = '{8'h03, 8'h06, 8'h07, 8'h08};
    step(1, 8'h06, 0);
    step(1, 8'h07, 0);
    step(1, 8'h08, 0);
`ifdef RING_BUFFER_DEBUG_EN
    checks++; if (debug2[17:0] !== 18'h1_0004) begin errors++; $display("FAIL ovf_full got %h exp 10004", debug2[17:0]); end
`endif
    step(1, 8'h09, 0);
`ifdef RING_BUFFER_DEBUG_EN
    checks++; if (debug2 !== 32'h0101_0004) begin errors++; $display("FAIL ovf_drop got %h exp 01010004", debug2); end
`endif
    for (int i = 0; i < 4; i++) begin
      step(0, 8'h00, 1);
      checks++; if ({dataReadAck, dataRead} !== {1'b1, exp[i]}) begin errors++; $display("FAIL ovf_rd%0d got %b/%h exp 1/%h", i, dataReadAck, dataRead, exp[i]); end
    end
  endtask

  task automatic test_underflow;
    for (int i = 0; i < 2; i++) begin
      step(0, 8'h00, 1);
      checks++; if ({dataReadAck, dataRead} !== {1'b0, 8'h08}) begin errors++; $display("FAIL unf_rd%0d got %b/%h exp 0/08", i, dataReadAck, dataRead); end
    end
`ifdef RING_BUFFER_DEBUG_EN
    checks++; if (debug !== 32'h0002_0002) begin errors++; $display("FAIL unf_ptrs got %h exp 00020002", debug); end
`endif
    step(1, 8'h55, 1);
    checks++; if ({dataReadAck, dataRead} !== {1'b0, 8'h08}) begin errors++; $display("FAIL unf_nobypass got %b/%h exp 0/08", dataReadAck, dataRead); end
    step(0, 8'h00, 1);
    checks++; if ({dataReadAck, dataRead} !== {1'b1, 8'h55}) begin errors++; $display("FAIL unf_after got %b/%h exp 1/55", dataReadAck, dataRead); end
  endtask

  task automatic test_wrap;
    for (int i = 0; i < 6; i++) begin
      step(1, 8'hA0 + 8'(i), 0);
      step(1, 8'hB0 + 8'(i), 0);
      step(0, 8'h00, 1);
      checks++; if ({dataReadAck, dataRead} !== {1'b1, 8'hA0 + 8'(i)}) begin errors++; $display("FAIL wrap_a%0d got %b/%h exp 1/%h", i, dataReadAck, dataRead, 8'hA0 + 8'(i)); end
      step(0, 8'h00, 1);
      checks++; if ({dataReadAck, dataRead} !== {1'b1, 8'hB0 + 8'(i)}) begin errors++; $display("FAIL wrap_b%0d got %b/%h exp 1/%h", i, dataReadAck, dataRead, 8'hB0 + 8'(i)); end
    end
  endtask

  task automatic test_concurrent_reset;
    step(1, 8'h11, 0);
    step(1, 8'h22, 0);
    step(1, 8'h33, 0);
    step(1, 8'h44, 0);
    step(1, 8'h55, 1);
    checks++; if ({dataReadAck, dataRead} !== {1'b1, 8'h11}) begin errors++; $display("FAIL conc_rd got %b/%h exp 1/11", dataReadAck, dataRead); end
`ifdef RING_BUFFER_DEBUG_EN
    checks++; if (debug2[17:0] !== 18'h1_0004) begin errors++; $display("FAIL conc_count got %h exp 10004", debug2[17:0]); end
`endif
    step(0, 8'h00, 1);
    checks++; if ({dataReadAck, dataRead} !== {1'b1, 8'h22}) begin errors++; $display("FAIL conc_rd2 got %b/%h exp 1/22", dataReadAck, dataRead); end
    @(negedge clk);
    writeEnable = 1; data = 8'h66; readEnable = 1; reset = 0;
    #1;
    checks++; if ({dataReadAck, dataRead} !== {1'b0, 8'h00}) begin errors++; $display("FAIL rst_async got %b/%h exp 0/00", dataReadAck, dataRead); end
    @(negedge clk);
    writeEnable = 0; readEnable = 0; reset = 1;
`ifdef RING_BUFFER_DEBUG_EN
    checks++; if ({debug, debug2} !== {32'h0, 32'h0002_0000}) begin errors++; $display("FAIL rst_debug got %h %h exp 0 00020000", debug, debug2); end
`endif
    step(0, 8'h00, 1);
    checks++; if (dataReadAck !== 1'b0) begin errors++; $display("FAIL rst_empty got %b exp 0", dataReadAck); end
    step(1, 8'h77, 0);
    step(0, 8'h00, 1);
    checks++; if ({dataReadAck, dataRead} !== {1'b1, 8'h77}) begin errors++; $display("FAIL rst_reuse got %b/%h exp 1/77", dataReadAck, dataRead); end
  endtask

  initial begin
    test_reset;
    test_fill_order;
    test_overflow;
    test_underflow;
    test_wrap;
    test_concurrent_reset;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
